// File: rtl/output_periph_ctrl.sv
// Memory-mapped LED/7-seg/LCD output peripheral (optional HEX_DECODE_EN: nibble storage with 7-seg decode).
// Latency: register stores land on the write edge; loads are combinational; LCD EN rises 3 edges after a push from idle.
// Backpressure: none toward the core; LCD pushes into a full FIFO are dropped and flag a sticky overflow.

module output_periph_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop_rdy,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    // A push is judged against the pre-pop fill level, so a full FIFO drops it even on a pop cycle.
    assign push_ok  = push_vld && !full;
    assign pop_ok   = pop_rdy && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

module output_periph_ctrl #(
    parameter int LEDR_W         = 18,
    parameter int LEDG_W         = 9,
    parameter int NUM_HEX        = 8,
    parameter int LCD_FIFO_DEPTH = 8,
    parameter int LCD_SETUP_CYC  = 2,
    parameter int LCD_STROBE_CYC = 12,
    parameter int LCD_HOLD_DEF   = 50
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [15:0]          i_addr,
    input  logic [31:0]          i_wr_data,
    input  logic                 i_wr_en,
    input  logic [3:0]           i_bmask,
    output logic [31:0]          o_ld_data,
    output logic [LEDR_W-1:0]    o_io_ledr,
    output logic [LEDG_W-1:0]    o_io_ledg,
    output logic [7*NUM_HEX-1:0] o_io_hex,
    output logic [31:0]          o_io_lcd,
    output logic                 o_lcd_busy
);
    localparam int CW = $clog2(LCD_FIFO_DEPTH) + 1;
`ifdef HEX_DECODE_EN
    localparam int HW = 5;
`else
    localparam int HW = 7;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    logic [LEDR_W-1:0] ledr_q;
    logic [LEDG_W-1:0] ledg_q;
    logic [HW-1:0]     hex_q [NUM_HEX];
    logic [15:0]       hold_q;
    logic              ovf_q;
    logic [30:0]       lcd_q;
    logic [15:0]       cnt_q;
    state_t            state_q, state_d;
    logic              en, pop;
    logic [30:0]       fifo_head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty, push_req;
    logic              a_ledr, a_ledg, a_hex, a_lcd, a_stat, a_hold;

    assign a_ledr   = (i_addr == 16'h7000);
    assign a_ledg   = (i_addr == 16'h7010);
    assign a_hex    = (i_addr[15:4] == 12'h702) && (int'(i_addr[3:0]) < NUM_HEX);
    assign a_lcd    = (i_addr == 16'h7030);
    assign a_stat   = (i_addr == 16'h7034);
    assign a_hold   = (i_addr == 16'h7038);
    assign push_req = i_wr_en && a_lcd && (|i_bmask);

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] m);
        merge = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) merge[8*b +: 8] = dat[8*b +: 8];
    endfunction

`ifdef HEX_DECODE_EN
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ledr_q <= '0;
            ledg_q <= '0;
            for (int k = 0; k < NUM_HEX; k++) hex_q[k] <= '0;
            hold_q <= 16'(LCD_HOLD_DEF);
            ovf_q  <= 1'b0;
        end else begin
            if (i_wr_en && a_ledr) ledr_q <= LEDR_W'(merge(32'(ledr_q), i_wr_data, i_bmask));
            if (i_wr_en && a_ledg) ledg_q <= LEDG_W'(merge(32'(ledg_q), i_wr_data, i_bmask));
            if (i_wr_en && a_hold) hold_q <= 16'(merge(32'(hold_q), i_wr_data, i_bmask));
            for (int k = 0; k < NUM_HEX; k++)
                if (i_wr_en && a_hex && i_bmask[0] && (i_addr[3:0] == 4'(k)))
                    hex_q[k] <= i_wr_data[HW-1:0];
            if (push_req && fifo_full)
                ovf_q <= 1'b1;
            else if (i_wr_en && a_stat && i_bmask[2] && i_wr_data[16])
                ovf_q <= 1'b0;
        end
    end

    output_periph_fifo #(.W(31), .DEPTH(LCD_FIFO_DEPTH)) u_lcd_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push_vld (push_req),
        .push_dat ({i_wr_data[31:11], i_wr_data[9:0]}),
        .pop_rdy  (pop),
        .head_dat (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Bit 10 is never stored: EN is spliced back in from the sequencer state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lcd_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pop) lcd_q <= fifo_head;
            case (state_q)
                S_IDLE:   cnt_q <= 16'(LCD_SETUP_CYC - 1);
                S_SETUP:  cnt_q <= (cnt_q == '0) ? 16'(LCD_STROBE_CYC - 1) : cnt_q - 16'd1;
                S_STROBE: cnt_q <= (cnt_q == '0) ? hold_q - 16'd1 : cnt_q - 16'd1;
                default:  cnt_q <= cnt_q - 16'd1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!fifo_empty) state_d = S_SETUP;
            S_SETUP:  if (cnt_q == '0) state_d = S_STROBE;
            S_STROBE: if (cnt_q == '0) state_d = (hold_q == '0) ? S_IDLE : S_HOLD;
            default:  if (cnt_q == '0) state_d = S_IDLE;
        endcase
    end

    always_comb begin
        en         = (state_q == S_STROBE);
        pop        = (state_q == S_IDLE) && !fifo_empty;
        o_lcd_busy = (state_q != S_IDLE) || !fifo_empty;
    end

    assign o_io_lcd  = {lcd_q[30:10], en, lcd_q[9:0]};
    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;

    always_comb begin
        o_io_hex = '0;
        for (int k = 0; k < NUM_HEX; k++) begin
`ifdef HEX_DECODE_EN
            o_io_hex[7*k +: 7] = hex_q[k][4] ? 7'h7F : seg7(hex_q[k][3:0]);
`else
            o_io_hex[7*k +: 7] = hex_q[k];
`endif
        end
    end

    always_comb begin
        o_ld_data = '0;
        if (a_ledr) o_ld_data = 32'(ledr_q);
        if (a_ledg) o_ld_data = 32'(ledg_q);
        if (a_stat) o_ld_data = {15'b0, ovf_q, o_lcd_busy, fifo_full, fifo_empty, 6'b0, 7'(fifo_count)};
        if (a_hold) o_ld_data = {16'b0, hold_q};
        for (int k = 0; k < NUM_HEX; k++)
            if (a_hex && (i_addr[3:0] == 4'(k))) o_ld_data = 32'(hex_q[k]);
    end
endmodule

// File: tb/tb_output_periph_ctrl.sv
// Directed bench for output_periph_ctrl; LCD words are scoreboarded and checked at each EN rise.
module tb_output_periph_ctrl;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_addr;
    logic [31:0] i_wr_data;
    logic        i_wr_en;
    logic [3:0]  i_bmask;
    logic [31:0] o_ld_data;
    logic [17:0] o_io_ledr;
    logic [8:0]  o_io_ledg;
    logic [55:0] o_io_hex;
    logic [31:0] o_io_lcd;
    logic        o_lcd_busy;

    output_periph_ctrl dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_addr     (i_addr),
        .i_wr_data  (i_wr_data),
        .i_wr_en    (i_wr_en),
        .i_bmask    (i_bmask),
        .o_ld_data  (o_ld_data),
        .o_io_ledr  (o_io_ledr),
        .o_io_ledg  (o_io_ledg),
        .o_io_hex   (o_io_hex),
        .o_io_lcd   (o_io_lcd),
        .o_lcd_busy (o_lcd_busy)
    );

    always #5 i_clk = ~i_clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic        en_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge i_clk);
        i_addr = a; i_wr_data = d; i_bmask = m; i_wr_en = 1'b1;
        @(posedge i_clk);
        #1 i_wr_en = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
        i_addr = a;
        #1 check(tag, o_ld_data, exp);
    endtask

    // Each EN rising edge must present the next queued word with EN forced high.
    always @(negedge i_clk) begin
        if (o_io_lcd[10] && !en_prev) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL lcd_extra: observed %h expected no strobe", o_io_lcd);
            end else begin
                check("lcd_word", o_io_lcd, exp_q.pop_front() | 32'h0000_0400);
            end
        end
        en_prev = o_io_lcd[10];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mask;
        logic        en_seen;

        i_rst = 1'b1; i_addr = '0; i_wr_data = '0; i_wr_en = 1'b0; i_bmask = '0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;

        check("rst_ledr", 32'(o_io_ledr), 32'h0);
        check("rst_ledg", 32'(o_io_ledg), 32'h0);
        check("rst_lcd", o_io_lcd, 32'h0);
        check("rst_busy", 32'(o_lcd_busy), 32'h0);
`ifdef HEX_DECODE_EN
        check("rst_hex0", 32'(o_io_hex[6:0]), 32'h40);
`else
        check("rst_hex0", 32'(o_io_hex[6:0]), 32'h0);
`endif
        rd_check("rst_status", 16'h7034, 32'h2000);
        rd_check("rst_hold", 16'h7038, 32'd50);

        // Byte-lane and width handling on the LED registers.
        wr(16'h7000, 32'hFFFF_FFFF, 4'b0011);
        check("ledr_mask", 32'(o_io_ledr), 32'h0FFFF);
        wr(16'h7021, 32'hFFFF_FFFF, 4'b1111);
        check("ledr_keep", 32'(o_io_ledr), 32'h0FFFF);
        check("hex1_ff", 32'(o_io_hex[13:7]), 32'h7F);
        rd_check("ld_ledr", 16'h7000, 32'h0000_FFFF);
        wr(16'h7000, 32'h0002_0000, 4'b0100);
        check("ledr_lane2", 32'(o_io_ledr), 32'h2FFFF);
        wr(16'h7004, 32'h0, 4'b1111);
        check("ledr_unmapped", 32'(o_io_ledr), 32'h2FFFF);
        wr(16'h7010, 32'h1234_5678, 4'b1111);
        check("ledg", 32'(o_io_ledg), 32'h078);
        rd_check("ld_ledg", 16'h7010, 32'h78);
        rd_check("ld_unmapped", 16'h7004, 32'h0);
        rd_check("ld_lcd_data", 16'h7030, 32'h0);
        rd_check("ld_hex_oob", 16'h7028, 32'h0);

        wr(16'h7023, 32'h0000_000A, 4'b0001);
`ifdef HEX_DECODE_EN
        check("hex3_dec_a", 32'(o_io_hex[27:21]), 32'h08);
        rd_check("ld_hex3_a", 16'h7023, 32'h0A);
        wr(16'h7023, 32'h0000_0010, 4'b0001);
        check("hex3_blank", 32'(o_io_hex[27:21]), 32'h7F);
        rd_check("ld_hex3_blank", 16'h7023, 32'h10);
        wr(16'h7023, 32'h0000_0005, 4'b1110);
        check("hex3_nolane", 32'(o_io_hex[27:21]), 32'h7F);
`else
        check("hex3_raw", 32'(o_io_hex[27:21]), 32'h0A);
        rd_check("ld_hex3", 16'h7023, 32'h0A);
        wr(16'h7023, 32'h0000_0055, 4'b1110);
        check("hex3_nolane", 32'(o_io_hex[27:21]), 32'h0A);
`endif

        // Reset asserted while EN is high aborts the strobe and restores defaults.
        wr(16'h7038, 32'h0000_0007, 4'b0011);
        rd_check("hold_wr", 16'h7038, 32'd7);
        wr(16'h7030, 32'h8000_0155, 4'b1111);
        exp_q.push_back(32'h8000_0155);
        for (int n = 0; n < 20 && !o_io_lcd[10]; n++) @(negedge i_clk);
        check("strobe_reached", 32'(o_io_lcd[10]), 32'h1);
        #2 i_rst = 1'b1;
        #1 check("rst_mid_lcd", o_io_lcd, 32'h0);
        check("rst_mid_busy", 32'(o_lcd_busy), 32'h0);
        check("rst_mid_ledr", 32'(o_io_ledr), 32'h0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        en_seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge i_clk);
            en_seen = en_seen | o_io_lcd[10];
        end
        check("rst_no_en", 32'(en_seen), 32'h0);
        check("rst_lcd_after", o_io_lcd, 32'h0);
        rd_check("rst_status_after", 16'h7034, 32'h2000);
        rd_check("rst_hold_after", 16'h7038, 32'd50);
        check("sb_after_rst", exp_q.size(), 32'h0);

        // Single push from idle: EN high in cycles 3..14 after the write edge, idle at cycle 65.
        wr(16'h7030, 32'h8000_0241, 4'b1111);
        exp_q.push_back(32'h8000_0241);
        mask = '0;
        for (int n = 0; n <= 66; n++) begin
            @(negedge i_clk);
            if (n < 32) mask[n] = o_io_lcd[10];
            if (n == 5)  check("lcd_strobe", o_io_lcd, 32'h8000_0641);
            if (n == 15) check("lcd_hold", o_io_lcd, 32'h8000_0241);
            if (n == 64) check("busy_c64", 32'(o_lcd_busy), 32'h1);
            if (n == 65) check("busy_c65", 32'(o_lcd_busy), 32'h0);
        end
        check("en_window", mask, 32'h0000_7FF8);

        // Ten back-to-back pushes into a depth-8 FIFO: one popped, eight queued, one dropped.
        for (int i = 0; i < 10; i++) begin
            wr(16'h7030, 32'h8000_0100 + 32'(i * 3), 4'b1111);
            if (i < 9) exp_q.push_back(32'h8000_0100 + 32'(i * 3));
        end
        rd_check("ovf_status", 16'h7034, 32'h0001_C008);
        wr(16'h7034, 32'h0001_0000, 4'b1111);
        rd_check("ovf_clear", 16'h7034, 32'h0000_C008);
        for (int n = 0; n < 1500 && o_lcd_busy; n++) @(negedge i_clk);
        check("drain_busy", 32'(o_lcd_busy), 32'h0);
        check("drain_sb", exp_q.size(), 32'h0);

        // Zero hold: next SETUP follows the STROBE after a single idle cycle.
        wr(16'h7038, 32'h0, 4'b0011);
        rd_check("hold_zero", 16'h7038, 32'h0);
        wr(16'h7030, 32'h1234_5678, 4'b1111);
        exp_q.push_back(32'h1234_5678);
        wr(16'h7030, 32'h0000_ABCD, 4'b1111);
        exp_q.push_back(32'h0000_ABCD);
        rd_check("push_pop_count", 16'h7034, 32'h0000_8001);
        mask = '0;
        for (int n = 1; n < 32; n++) begin
            @(negedge i_clk);
            mask[n] = o_io_lcd[10];
            if (n == 15) check("lcd_idle_en_low", o_io_lcd, 32'h1234_5278);
        end
        check("en_window_h0", mask, 32'h3FFC_7FF8);
        for (int n = 0; n < 100 && o_lcd_busy; n++) @(negedge i_clk);
        check("h0_busy", 32'(o_lcd_busy), 32'h0);
        check("h0_sb", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/output_periph_ctrl.md
Name: output_periph_ctrl

Overview:
Parametrised memory-mapped output peripheral for the single-cycle core's store/load path. It holds the LEDR, LEDG and NUM_HEX seven-segment registers, with byte-mask writes. LCD writes go through a FIFO and a timed strobe sequencer, so the core can issue back-to-back LCD stores without software delay loops. Load data is combinational, for single-cycle LW.

Parameters:
LEDR_W, 18, red LED register width (≤32)
LEDG_W, 9, green LED register width (≤32)
NUM_HEX, 8, number of 7-seg digit registers (1..16)
LCD_FIFO_DEPTH, 8, LCD FIFO entries (power of 2, 2..64)
LCD_SETUP_CYC, 2, cycles data is stable before EN rises (≥1)
LCD_STROBE_CYC, 12, EN-high cycles (≥1)
LCD_HOLD_DEF, 50, reset value of programmable post-strobe hold count (16-bit)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_addr  in  16  byte address from LSU
i_wr_data  in  32  store data
i_wr_en  in  1  store strobe, one cycle per store
i_bmask  in  4  byte-lane enables for store
o_ld_data  out  32  combinational load data
o_io_ledr  out  LEDR_W  red LEDs
o_io_ledg  out  LEDG_W  green LEDs
o_io_hex  out  7*NUM_HEX  digit k at [7k+6:7k]
o_io_lcd  out  32  LCD bus: [31] ON, [10] EN, [9] RS, [8] RW, [7:0] DATA
o_lcd_busy  out  1  sequencer not IDLE or FIFO not empty

Behaviour:
- Address map: 0x7000 LEDR; 0x7010 LEDG; 0x7020+k HEX k (k<NUM_HEX); 0x7030 LCD data push (write only; reads return 0); 0x7034 LCD status; 0x7038 LCD hold count [15:0].
- Reset (i_rst=1, asynchronous): all registers 0, o_io_lcd=0, FIFO empty, overflow=0, hold=LCD_HOLD_DEF, state IDLE, o_lcd_busy=0. Reset asserted mid-strobe aborts the transfer immediately; EN drops to 0 on assertion.
- Register writes take effect on the rising edge where i_wr_en=1. A byte lane is updated only when its i_bmask bit is set. Bits beyond the register width are discarded. Unmapped addresses and unimplemented HEX indices are ignored. All other registers retain their values; there is no clear-on-miss.
- HEX k stores i_wr_data[6:0] when i_bmask[0]=1.
- LCD push: write to 0x7030 with any i_bmask bit set enqueues i_wr_data. If the FIFO is full, the word is dropped and sticky overflow is set.
- Status read: [16] overflow, [15] busy, [14] full, [13] empty, [6:0] count. Writing 0x7034 with i_wr_data[16]=1 clears overflow.
- Simultaneous push and pop in the same cycle: count unchanged. A push to a full FIFO is dropped even if a pop occurs in the same cycle.
- Sequencer FSM:
  - IDLE: if FIFO not empty, pop the head into the output register and go to SETUP. EN=0.
  - SETUP: LCD_SETUP_CYC cycles, EN=0.
  - STROBE: LCD_STROBE_CYC cycles, EN=1.
  - HOLD: hold-count cycles, EN=0; then go to IDLE. A hold count of 0 means go to IDLE next cycle.
  - o_io_lcd shows the popped word with bit 10 overridden by EN. It holds the last word, EN=0, in IDLE.
  - Pop-to-EN-rise latency = 1 + LCD_SETUP_CYC cycles.
- Writing the hold count mid-transfer affects the next HOLD entry only; the count is sampled on HOLD entry.
- o_ld_data is combinational from i_addr: zero-extended register contents, 0 for unmapped addresses.

Optional Feature:
HEX_DECODE_EN
- Defined: HEX k stores the 4-bit nibble i_wr_data[3:0]. The output is decoded to active-low 7-seg (0→7'h40, 1→7'h79, …, F→7'h0E). Bit [4] of the stored value (i_wr_data[4]) = blank, forcing 7'h7F. Loads return {27'b0, blank, nibble}. Reset value decodes to 7'h40.
- Undefined: raw 7-bit segment storage as described above.

Test Plan:
- Reset mid-LCD-strobe, then release → all outputs 0; status reads 0x2000; EN never glitches high after reset.
- Store 0xFFFFFFFF to 0x7000 with i_bmask=4'b0011 → o_io_ledr=18'h0FFFF. Then store to 0x7021 → LEDR unchanged; load 0x7000 returns 0x0000FFFF.
- Push 0x80000241 to 0x7030 from IDLE → EN high cycles 3..14 after the write edge. o_io_lcd=0x80000641 during STROBE, then 0x80000241. Busy=0 exactly 1+2+12+50 cycles after the pop.
- Push 10 words back-to-back with depth 8 → first word popped immediately, 8 queued, 1 dropped. Status overflow=1 and full=1. Write 0x00010000 to 0x7034 → overflow=0. Remaining 9 words appear on the LCD in order.
- Write hold=0 at 0x7038, push 2 words → second SETUP starts 1 cycle after first STROBE ends. Push in the same cycle as a pop leaves count unchanged.
- HEX_DECODE_EN defined: write 0x0A to 0x7023 → o_io_hex[27:21]=7'h08. Write 0x10 → 7'h7F.
